xgmii_frame_gen: RTL

// - Transmit-side XGMII test-traffic source. Drives the 64-bit SDR XGMII TX inputs (txd/txc) of one eth_xcvr_phy_wrapper lane.
// - Emits well-formed start/data/terminate/idle sequences for link bring-up and loopback checks, without a MAC.
// - Payload is a deterministic byte pattern. No FCS is appended.
// - Runs in the PHY TX clock domain: phy_tx_clk / phy_tx_rst, 156.25 MHz.

---
 rtl/xgmii_frame_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/xgmii_frame_gen.sv
// XGMII TX test-traffic source: start, patterned payload, terminate, IFG.
// Payload byte k is k[7:0] ^ frame_count[7:0]; no FCS is appended.
module xgmii_frame_gen #(
  parameter int IFG_WORDS   = 2,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [15:0]            len,
  output logic [63:0]            xgmii_txd,
  output logic [7:0]             xgmii_txc,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_TERM,
    S_IFG
  } state_t;

  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [63:0] START_D = 64'hD5555555555555FB;
  localparam logic [3:0]  IFG_LAST = 4'(IFG_WORDS - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [15:0]            r_len;
  logic [15:0]            r_k;
  logic [3:0]             r_ifg;
  logic [63:0]            r_txd;
  logic [7:0]             r_txc;
  logic                   r_busy;
  logic [COUNT_WIDTH-1:0] r_fc;

  logic [15:0] w_rem;
  logic [15:0] w_k_next;
  logic [3:0]  w_ifg_next;
  logic [63:0] w_txd;
  logic [7:0]  w_txc;
  logic        w_go;
  logic        w_len_ld;
  logic        w_fc_inc;
  logic [7:0]  w_seed;

  assign w_rem  = r_len - r_k;
  assign w_go   = enable && (len != 16'd0);
  assign w_seed = 8'(r_fc);

  always_comb begin
    w_next     = r_state;
    w_txd      = IDLE_D;
    w_txc      = 8'hFF;
    w_k_next   = r_k;
    w_ifg_next = r_ifg;
    w_len_ld   = 1'b0;
    w_fc_inc   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_next   = S_START;
          w_len_ld = 1'b1;
        end
      end
      S_START: begin
        w_txd    = START_D;
        w_txc    = 8'h01;
        w_k_next = 16'd0;
        w_next   = (r_len < 16'd8) ? S_TERM : S_DATA;
      end
      S_DATA: begin
        for (int i = 0; i < 8; i++) begin
          w_txd[8*i +: 8] = (r_k[7:0] + 8'(i)) ^ w_seed;
        end
        w_txc    = 8'h00;
        w_k_next = r_k + 16'd8;
        if (w_rem < 16'd16) w_next = S_TERM;
      end
      S_TERM: begin
        // Remaining 0..7 bytes, then FD, then 07 fill.
        for (int i = 0; i < 8; i++) begin
          if (16'(i) < w_rem) begin
            w_txd[8*i +: 8] = (r_k[7:0] + 8'(i)) ^ w_seed;
            w_txc[i]        = 1'b0;
          end else if (16'(i) == w_rem) begin
            w_txd[8*i +: 8] = 8'hFD;
          end
        end
        w_fc_inc   = 1'b1;
        w_ifg_next = 4'd0;
        w_next     = S_IFG;
      end
      S_IFG: begin
        w_ifg_next = r_ifg + 4'd1;
        if (r_ifg == IFG_LAST) begin
          w_ifg_next = 4'd0;
          if (w_go) begin
            w_next   = S_START;
            w_len_ld = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= 16'd0;
      r_k     <= 16'd0;
      r_ifg   <= 4'd0;
      r_txd   <= IDLE_D;
      r_txc   <= 8'hFF;
      r_busy  <= 1'b0;
      r_fc    <= '0;
    end else begin
      r_state <= w_next;
      r_k     <= w_k_next;
      r_ifg   <= w_ifg_next;
      r_txd   <= w_txd;
      r_txc   <= w_txc;
      r_busy  <= (r_state != S_IDLE);
      if (w_len_ld) r_len <= len;
      if (w_fc_inc) r_fc <= r_fc + 1'b1;
    end
  end

  assign xgmii_txd   = r_txd;
  assign xgmii_txc   = r_txc;
  assign busy        = r_busy;
  assign frame_count = r_fc;

endmodule
